// File: rtl/bram_pkg.sv
// Shared types and helpers for the simple-dual-port BRAM golden model.
// Optional parity storage is enabled with `define BRAM_PARITY_EN.
package bram_pkg;

  localparam int RD_LAT_MAX = 2;
  localparam int DATA_W_MAX = 72;

  typedef enum logic {
    RDW_READ_FIRST  = 1'b0,
    RDW_WRITE_FIRST = 1'b1
  } rdw_mode_e;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } clr_state_e;

  // Narrower words are zero-extended by the caller; zeros do not change the XOR.
  function automatic logic parity_even(input logic [DATA_W_MAX-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/bram_rd_pipe.sv
// Optional output register stage of the BRAM read path (present when RD_LAT = 2).
// Carries a parity-error flag alongside the data when BRAM_PARITY_EN is defined.
module bram_rd_pipe
  import bram_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
`ifdef BRAM_PARITY_EN
  input  logic              in_perr,
  output logic              out_perr,
`endif
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  generate
    if (RD_LAT >= RD_LAT_MAX) begin : g_out_reg
      // Data only loads on a valid beat so rd_data holds between reads.
      always_ff @(posedge clock) begin
        if (reset) begin
          out_valid <= 1'b0;
          out_data  <= '0;
`ifdef BRAM_PARITY_EN
          out_perr  <= 1'b0;
`endif
        end else begin
          out_valid <= in_valid;
          if (in_valid) out_data <= in_data;
`ifdef BRAM_PARITY_EN
          out_perr  <= in_valid && in_perr;
`endif
        end
      end
    end else begin : g_bypass
      logic unused_bypass;
      assign unused_bypass = ^{clock, reset};
      assign out_valid     = in_valid;
      assign out_data      = in_data;
`ifdef BRAM_PARITY_EN
      assign out_perr      = in_perr;
`endif
    end
  endgenerate

endmodule

// File: rtl/bram_sdp_param.sv
// Parametrised simple-dual-port block memory with post-reset clear sweep and read-valid pipeline.
// Define BRAM_PARITY_EN to store a per-word even-parity bit and report rd_perr.
module bram_sdp_param
  import bram_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 8,
  parameter int DEPTH      = 256,
  parameter int RD_LAT     = 1,
  parameter int RDW_MODE   = 0,
  parameter int INIT_CLEAR = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
`ifdef BRAM_PARITY_EN
  input  logic              wr_perr_inject,
  output logic              rd_perr,
`endif
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              init_busy
);

`ifdef BRAM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  localparam logic [0:0]      ST_CLEAR = CLEAR;
  localparam logic [0:0]      ST_READY = READY;
  localparam rdw_mode_e       RDW      = rdw_mode_e'(RDW_MODE[0]);
  localparam logic [ADDR_W:0] DEPTH_X  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] CLR_LAST = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] CLR_ONE  = (ADDR_W+1)'(1);

  logic [0:0]        state;
  logic [ADDR_W:0]   clr_cnt;
  logic [MEM_W-1:0]  mem [DEPTH];
  logic              clr_we;
  logic              wr_accept;
  logic              rd_accept;
  logic              rd_in_range;
  logic [MEM_W-1:0]  wr_word;
  logic [MEM_W-1:0]  rd_word;
  logic              s1_valid;
  logic [DATA_W-1:0] s1_data;
`ifdef BRAM_PARITY_EN
  logic              s1_perr;
`endif

  assign init_busy   = (state == ST_CLEAR);
  assign clr_we      = init_busy && !reset;
  assign wr_accept   = !reset && !init_busy && wr_en && ({1'b0, wr_addr} < DEPTH_X);
  assign rd_accept   = !reset && !init_busy && rd_en;
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_X);

`ifdef BRAM_PARITY_EN
  assign wr_word = {parity_even(DATA_W_MAX'(wr_data)) ^ wr_perr_inject, wr_data};
`else
  assign wr_word = wr_data;
`endif

  // clr_cnt carries one spare bit so DEPTH = 2**ADDR_W cannot wrap before the compare.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_READY;
      clr_cnt <= '0;
    end else if (state == ST_CLEAR) begin
      clr_cnt <= clr_cnt + CLR_ONE;
      if (clr_cnt == CLR_LAST) state <= ST_READY;
    end
  end

  always_ff @(posedge clock) begin
    if (clr_we) mem[clr_cnt[ADDR_W-1:0]] <= '0;
    else if (wr_accept) mem[wr_addr] <= wr_word;
  end

  // Read-first falls out of the array read seeing pre-edge contents; write-first bypasses.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      if ((RDW == RDW_WRITE_FIRST) && wr_accept && (wr_addr == rd_addr)) rd_word = wr_word;
      else rd_word = mem[rd_addr];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
`ifdef BRAM_PARITY_EN
      s1_perr  <= 1'b0;
`endif
    end else begin
      s1_valid <= rd_accept;
      if (rd_accept) s1_data <= rd_word[DATA_W-1:0];
`ifdef BRAM_PARITY_EN
      s1_perr  <= rd_accept && (parity_even(DATA_W_MAX'(rd_word[DATA_W-1:0])) != rd_word[DATA_W]);
`endif
    end
  end

  bram_rd_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (s1_valid),
    .in_data   (s1_data),
`ifdef BRAM_PARITY_EN
    .in_perr   (s1_perr),
    .out_perr  (rd_perr),
`endif
    .out_valid (rd_valid),
    .out_data  (rd_data)
  );

endmodule
